// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Access size/sign, funct3 encoding
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for mem_arbiter. MEM_ARB_RR_EN selects round robin with a
// last-owner register; otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic grant_i,
`endif
    input  logic req0_i,
    input  logic req1_i,
    output logic winner_o
);

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Reset value makes port 0 the winner of the first contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PORT1;
        end else if (grant_i) begin
            last_q <= winner_o;
        end
    end

    always_comb begin
        winner_o = PORT0;
        if (req0_i && req1_i) begin
            winner_o = ~last_q;
        end else if (req1_i) begin
            winner_o = PORT1;
        end
    end
`else
    assign winner_o = (req1_i && !req0_i) ? PORT1 : PORT0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one shared memory: IDLE -> ISSUE -> RESP, one
// transaction in flight. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    output logic              p0_gnt,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_we,
    input  logic [2:0]        p0_mode,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    output logic              p1_gnt,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_we,
    input  logic [2:0]        p1_mode,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addrs,
    output logic [DATA_W-1:0] data_mem_OUT,
    input  logic [DATA_W-1:0] data_mem_IN,
    output logic [2:0]        mem_MODE,
    output logic              mem_WE,
    output logic              busy
);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        mode_q;
    logic              we_q;
    logic              mem_we_q;
    logic              owner_q;
    logic              done0_q;
    logic              done1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              any_req;
    logic              winner;
    logic              grant;
    logic              resp_rd;

    assign any_req = p0_req | p1_req;
    assign grant   = reset && (state_q == IDLE) && any_req;
    assign p0_gnt  = grant && (winner == PORT0);
    assign p1_gnt  = grant && (winner == PORT1);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .reset    (reset),
        .grant_i  (grant),
`endif
        .req0_i   (p0_req),
        .req1_i   (p1_req),
        .winner_o (winner)
    );

    // The request latches double as the memory-side outputs: loaded only on
    // grant, so they present in ISSUE and hold their last value elsewhere.
    assign mem_addrs    = addr_q;
    assign data_mem_OUT = wdata_q;
    assign mem_MODE     = mode_q;
    assign mem_WE       = mem_we_q;
    assign busy         = (state_q != IDLE);
    assign p0_done      = done0_q;
    assign p1_done      = done1_q;

    // Read data is forwarded in RESP so it is valid alongside done
    assign resp_rd  = (state_q == RESP) && !we_q;
    assign p0_rdata = (resp_rd && owner_q == PORT0) ? data_mem_IN : rdata0_q;
    assign p1_rdata = (resp_rd && owner_q == PORT1) ? data_mem_IN : rdata1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mode_q   <= '0;
            we_q     <= 1'b0;
            mem_we_q <= 1'b0;
            owner_q  <= PORT0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q  <= winner;
                        addr_q   <= (winner == PORT1) ? p1_addr  : p0_addr;
                        wdata_q  <= (winner == PORT1) ? p1_wdata : p0_wdata;
                        mode_q   <= (winner == PORT1) ? p1_mode  : p0_mode;
                        we_q     <= (winner == PORT1) ? p1_we    : p0_we;
                        mem_we_q <= (winner == PORT1) ? p1_we    : p0_we;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we_q <= 1'b0;
                    done0_q  <= (owner_q == PORT0);
                    done1_q  <= (owner_q == PORT1);
                    state_q  <= RESP;
                end
                RESP: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (!we_q && owner_q == PORT0) rdata0_q <= data_mem_IN;
                    if (!we_q && owner_q == PORT1) rdata1_q <= data_mem_IN;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory and a
// completion scoreboard; covers both the fixed and MEM_ARB_RR_EN builds.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_gnt, p0_we, p0_done;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_mode;
    logic        p1_req, p1_gnt, p1_we, p1_done;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_mode;
    logic [31:0] mem_addrs, data_mem_OUT, data_mem_IN;
    logic [2:0]  mem_MODE;
    logic        mem_WE, busy;

    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic        mon_port;
    logic [31:0] mon_rdata;
    logic [31:0] mem_m [logic [31:0]];
    int          tests = 0;
    int          fails = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_we(p0_we), .p0_mode(p0_mode), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_we(p1_we), .p1_mode(p1_mode), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_addrs(mem_addrs), .data_mem_OUT(data_mem_OUT), .data_mem_IN(data_mem_IN),
        .mem_MODE(mem_MODE), .mem_WE(mem_WE), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Synchronous-read memory: data appears one cycle after the address
    always @(posedge clk) begin
        data_mem_IN <= mem_m.exists(mem_addrs) ? mem_m[mem_addrs] : 32'h0;
        if (mem_WE) mem_m[mem_addrs] = data_mem_OUT;
    end

    // Scoreboard: every done pulse must match the next expected completion
    always @(negedge clk) begin
        if (p0_done && p1_done) begin
            tests++; fails++;
            $display("FAIL done_overlap p0_done=1 p1_done=1 expected at most one");
        end else if (p0_done || p1_done) begin
            tests++;
            mon_port  = p1_done;
            mon_rdata = p1_done ? p1_rdata : p0_rdata;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_done port=%0d expected no completion", mon_port);
            end else begin
                mon_e = sb.pop_front();
                if (mon_port !== mon_e.port || (mon_e.rd && mon_rdata !== mon_e.rdata)) begin
                    fails++;
                    $display("FAIL sb_done port=%0d rdata=%h expected port=%0d rdata=%h",
                             mon_port, mon_rdata, mon_e.port, mon_e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        p0_req = 1'b1; p0_addr = '0; p0_wdata = '0; p0_we = 1'b0; p0_mode = '0;
        p1_req = 1'b1; p1_addr = '0; p1_wdata = '0; p1_we = 1'b0; p1_mode = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({p0_gnt, p1_gnt, p0_done, p1_done, mem_WE, busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl gnt=%b%b done=%b%b we=%b busy=%b expected all 0",
                     p0_gnt, p1_gnt, p0_done, p1_done, mem_WE, busy);
        end
        tests++;
        if ({mem_addrs, data_mem_OUT, mem_MODE, p0_rdata, p1_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_data addr=%h wdata=%h mode=%b r0=%h r1=%h expected all 0",
                     mem_addrs, data_mem_OUT, mem_MODE, p0_rdata, p1_rdata);
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_read_p0();
        @(posedge clk); #1;
        p0_addr = 32'h100; p0_we = 1'b0; p0_mode = MODE_W; p0_req = 1'b1;
        @(negedge clk);
        tests++;
        if ({p0_gnt, p1_gnt, busy} !== 3'b100) begin
            fails++;
            $display("FAIL rd_gnt gnt=%b%b busy=%b expected gnt=10 busy=0", p0_gnt, p1_gnt, busy);
        end
        sb.push_back('{PORT0, 1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_addrs, mem_WE, mem_MODE, busy} !== {32'h100, 1'b0, MODE_W, 1'b1}) begin
            fails++;
            $display("FAIL rd_issue addr=%h we=%b mode=%b busy=%b expected 00000100 0 010 1",
                     mem_addrs, mem_WE, mem_MODE, busy);
        end
        @(negedge clk);
        tests++;
        if ({p0_done, p1_done, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL rd_resp done=%b%b rdata=%h expected done=10 rdata=deadbeef",
                     p0_done, p1_done, p0_rdata);
        end
        @(negedge clk);
        tests++;
        if ({busy, p0_done, p0_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL rd_hold busy=%b done=%b rdata=%h expected 0 0 deadbeef",
                     busy, p0_done, p0_rdata);
        end
    endtask

    task automatic test_write_p1();
        @(posedge clk); #1;
        p1_addr = 32'h200; p1_wdata = 32'h12345678; p1_we = 1'b1; p1_mode = MODE_W; p1_req = 1'b1;
        @(negedge clk);
        tests++;
        if ({p0_gnt, p1_gnt, mem_WE} !== 3'b010) begin
            fails++;
            $display("FAIL wr_gnt gnt=%b%b we=%b expected gnt=01 we=0", p0_gnt, p1_gnt, mem_WE);
        end
        sb.push_back('{PORT1, 1'b0, 32'h0});
        @(posedge clk); #1;
        p1_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_WE, mem_addrs, data_mem_OUT, mem_MODE} !== {1'b1, 32'h200, 32'h12345678, MODE_W}) begin
            fails++;
            $display("FAIL wr_issue we=%b addr=%h data=%h mode=%b expected 1 00000200 12345678 010",
                     mem_WE, mem_addrs, data_mem_OUT, mem_MODE);
        end
        @(negedge clk);
        tests++;
        if ({mem_WE, p1_done, p0_done, p0_gnt} !== 4'b0100) begin
            fails++;
            $display("FAIL wr_resp we=%b p1_done=%b p0_done=%b p0_gnt=%b expected 0 1 0 0",
                     mem_WE, p1_done, p0_done, p0_gnt);
        end
        @(negedge clk);
        tests++;
        if ({mem_WE, busy} !== 2'b00) begin
            fails++;
            $display("FAIL wr_idle we=%b busy=%b expected 0 0", mem_WE, busy);
        end
        @(posedge clk); #1;
        p1_we = 1'b0; p1_req = 1'b1;
        @(negedge clk);
        tests++;
        if (p1_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rdback_gnt p1_gnt=%b expected 1", p1_gnt);
        end
        sb.push_back('{PORT1, 1'b1, 32'h12345678});
        @(posedge clk); #1;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({p1_done, p1_rdata, p0_rdata} !== {1'b1, 32'h12345678, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL rdback_resp p1_done=%b p1_rdata=%h p0_rdata=%h expected 1 12345678 deadbeef",
                     p1_done, p1_rdata, p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_port;
        @(posedge clk); #1;
        p0_addr = 32'h300; p0_we = 1'b0; p0_mode = MODE_W; p0_req = 1'b1;
        p1_addr = 32'h304; p1_we = 1'b0; p1_mode = MODE_W; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_port = k[0];
`else
            exp_port = PORT0;
`endif
            tests++;
            if ({p0_gnt, p1_gnt} !== (exp_port ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL cont_gnt k=%0d gnt=%b%b expected port %0d", k, p0_gnt, p1_gnt, exp_port);
            end
            sb.push_back('{exp_port, 1'b1, exp_port ? 32'hB1B1B1B1 : 32'hA0A0A0A0});
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                tests++;
                if ({p0_gnt, p1_gnt} !== 2'b00) begin
                    fails++;
                    $display("FAIL cont_busy_gnt k=%0d j=%0d gnt=%b%b expected 00", k, j, p0_gnt, p1_gnt);
                end
            end
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({p0_gnt, p1_gnt, busy} !== 3'b000) begin
            fails++;
            $display("FAIL cont_end gnt=%b%b busy=%b expected 000", p0_gnt, p1_gnt, busy);
        end
    endtask

    task automatic test_reset_in_issue();
        @(posedge clk); #1;
        p0_addr = 32'h400; p0_wdata = 32'h55; p0_we = 1'b1; p0_mode = MODE_W; p0_req = 1'b1;
        p1_addr = 32'h304; p1_we = 1'b0; p1_req = 1'b1;
        @(negedge clk);
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL rst_gnt gnt=%b%b expected 10", p0_gnt, p1_gnt);
        end
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_WE !== 1'b1) begin
            fails++;
            $display("FAIL rst_issue_we we=%b expected 1", mem_WE);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({mem_WE, busy, p0_gnt, p1_gnt, p0_rdata} !== '0) begin
            fails++;
            $display("FAIL rst_abort we=%b busy=%b gnt=%b%b r0=%h expected all 0",
                     mem_WE, busy, p0_gnt, p1_gnt, p0_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({p0_done, p1_done} !== 2'b00) begin
            fails++;
            $display("FAIL rst_no_done done=%b%b expected 00", p0_done, p1_done);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({p1_gnt, p0_gnt, busy} !== 3'b100) begin
            fails++;
            $display("FAIL rst_regrant p1_gnt=%b p0_gnt=%b busy=%b expected 1 0 0", p1_gnt, p0_gnt, busy);
        end
        sb.push_back('{PORT1, 1'b1, 32'hB1B1B1B1});
        @(posedge clk); #1;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({p1_done, p1_rdata} !== {1'b1, 32'hB1B1B1B1}) begin
            fails++;
            $display("FAIL rst_resp p1_done=%b p1_rdata=%h expected 1 b1b1b1b1", p1_done, p1_rdata);
        end
        tests++;
        if (mem_m.exists(32'h400)) begin
            fails++;
            $display("FAIL rst_no_write mem[400] written=1 expected not written");
        end
        @(negedge clk);
    endtask

    task automatic test_req_change();
        @(posedge clk); #1;
        p0_addr = 32'h100; p0_we = 1'b0; p0_mode = MODE_BU; p0_req = 1'b1;
        @(negedge clk);
        tests++;
        if (p0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL chg_gnt p0_gnt=%b expected 1", p0_gnt);
        end
        sb.push_back('{PORT0, 1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;
        p0_req = 1'b0; p0_addr = 32'h999; p0_mode = MODE_B; p0_we = 1'b1;
        @(negedge clk);
        tests++;
        if ({mem_addrs, mem_MODE, mem_WE} !== {32'h100, MODE_BU, 1'b0}) begin
            fails++;
            $display("FAIL chg_issue addr=%h mode=%b we=%b expected 00000100 100 0",
                     mem_addrs, mem_MODE, mem_WE);
        end
        @(negedge clk);
        tests++;
        if (p0_done !== 1'b1) begin
            fails++;
            $display("FAIL chg_done p0_done=%b expected 1", p0_done);
        end
        @(negedge clk);
        tests++;
        if ({busy, p0_gnt, mem_addrs, mem_MODE} !== {2'b00, 32'h100, MODE_BU}) begin
            fails++;
            $display("FAIL chg_hold busy=%b gnt=%b addr=%h mode=%b expected 0 0 00000100 100",
                     busy, p0_gnt, mem_addrs, mem_MODE);
        end
    endtask

    initial begin
        mem_m[32'h100] = 32'hDEADBEEF;
        mem_m[32'h300] = 32'hA0A0A0A0;
        mem_m[32'h304] = 32'hB1B1B1B1;
        test_reset();
        test_read_p0();
        test_write_p1();
        test_contention();
        test_reset_in_issue();
        test_req_change();
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain pending=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
